uni_shift_reg: RTL and testbench
================================

# uni_shift_reg

Parametrised universal shift register: the successor to the single-bit D flip-flop, generalised to a WIDTH-bit register with hold, parallel load, shift, rotate, arithmetic-shift and clear modes. It adds an autonomous burst engine that performs a programmed number of shifts and reports busy/done. It sits between parallel datapaths and serial links, serving as a serialiser/deserialiser, delay element or bit-manipulation stage.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- CW, 4, burst-count width; max burst = 2^CW−1 shifts

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- en  in  1  clock enable for manual modes and burst steps
- mode  in  3  manual operation select (see Operation)
- sin  in  1  serial input bit
- pdata  in  WIDTH  parallel load data
- start  in  1  burst start strobe
- bdir  in  1  burst direction: 0 = shift left, 1 = shift right
- bcnt  in  CW  burst shift count, sampled on start
- q  out  WIDTH  register contents
- sout  out  1  last bit shifted out (registered)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when burst completes
- parity  out  1  XOR of q (see Configuration)

## Operation
- Manual modes apply when busy=0, en=1 and start=0:
  - 000 hold
  - 001 load: q←pdata
  - 010 shl: q←{q[W−2:0],sin}, sout←q[W−1]
  - 011 shr: q←{sin,q[W−1:1]}, sout←q[0]
  - 100 rotl: q←{q[W−2:0],q[W−1]}, sout←q[W−1]
  - 101 rotr: q←{q[0],q[W−1:1]}, sout←q[0]
  - 110 asr: q←{q[W−1],q[W−1:1]}, sout←q[0]
  - 111 clear: q←0, sout unchanged
- en=0 with busy=0: q and sout hold regardless of mode.
- FSM states are IDLE, SHIFT and DONE:
  - IDLE→SHIFT on start=1 when bcnt≠0. Latch the remaining count ←bcnt and dir ←bdir.
  - IDLE→DONE on start=1 when bcnt=0. No shift occurs.
  - SHIFT: each cycle with en=1, perform one shl (bdir=0) or shr (bdir=1) using sin, then decrement the remaining count. When a step brings it to 0, go to DONE. Cycles with en=0 stall the burst; state and count are held.
  - DONE→IDLE unconditionally after 1 cycle.
- busy=1 in SHIFT and DONE. done=1 only in DONE.
- start has priority over mode in IDLE. While busy, start and mode are ignored.
- A start in the DONE cycle is ignored. A new burst may be started the cycle after done.

## Timing
- Reset values: q=0, sout=0, busy=0, done=0, parity=0, FSM=IDLE, remaining count=0.
- Manual ops: single-cycle latency. q and sout are valid after the edge on which they are sampled.
- Burst of N shifts with en held high:
  - start is sampled at edge 0.
  - busy rises after edge 0.
  - Shifts occur at edges 1..N.
  - done is high for the cycle after edge N.
  - busy falls after edge N+1.
- Burst with bcnt=0: done is high the cycle after start, and q is unchanged.
- rst during a burst: on the next edge, all state returns to reset values. No done pulse is issued.
- Count arithmetic is unsigned CW-bit. The count never underflows: the decrement occurs only when the count is nonzero.

## Configuration
- SHREG_PARITY_EN defined: parity is a registered even-parity bit equal to ^q. It updates on the same edge as q, so it always matches the currently visible q.
- Macro undefined: the parity port remains, tied to constant 0, and no parity logic is built.

## Test plan
- Reset then load: rst=1 for 2 cycles → q=0, busy=0. Then mode=001 with pdata=8'hA5 → q=8'hA5 next cycle; parity=0 if enabled.
- Manual shifts: q=8'h81, shl with sin=0 → q=8'h02, sout=1. Then rotr → q=8'h01, sout=0. Then asr on 8'h80 → 8'hC0.
- Burst serialise: q=8'hB4, start with bcnt=8, bdir=0, sin=0 → sout sequence 1,0,1,1,0,1,0,0 at edges 1..8; done pulse in cycle 9; q=0.
- Burst stall and ignore: bcnt=3, en low for 2 cycles mid-burst, toggle mode and start while busy → exactly 3 shifts, done delayed by 2 cycles, mode ignored.
- Boundaries: bcnt=0 → done next cycle with q unchanged. rst asserted after the 2nd of 5 burst shifts → busy=0, done never pulses, q=0.

Source files
------------

// File: rtl/uni_shift_reg.sv
// Universal WIDTH-bit shift register with manual modes and an autonomous burst shifter.
// Optional feature: define SHREG_PARITY_EN for a registered even-parity output.
module uni_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic             bdir,
  input  logic [CW-1:0]    bcnt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             parity
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_sout, w_sout_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_sout  <= w_sout_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_sout_nxt  = r_sout;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    unique case (r_state)
      IDLE: begin
        // start outranks mode and does not need en
        if (start) begin
          w_cnt_nxt   = bcnt;
          w_dir_nxt   = bdir;
          w_state_nxt = (bcnt == '0) ? DONE : SHIFT;
        end else if (en) begin
          unique case (mode)
            3'b000: ;
            3'b001: w_q_nxt = pdata;
            3'b010: begin w_q_nxt = {r_q[WIDTH-2:0], sin};        w_sout_nxt = r_q[WIDTH-1]; end
            3'b011: begin w_q_nxt = {sin, r_q[WIDTH-1:1]};        w_sout_nxt = r_q[0];       end
            3'b100: begin w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]}; w_sout_nxt = r_q[WIDTH-1]; end
            3'b101: begin w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};     w_sout_nxt = r_q[0];       end
            3'b110: begin w_q_nxt = {r_q[WIDTH-1], r_q[WIDTH-1:1]}; w_sout_nxt = r_q[0];     end
            default: w_q_nxt = '0;
          endcase
        end
      end
      SHIFT: begin
        if (en && r_cnt != '0) begin
          if (r_dir) begin
            w_q_nxt    = {sin, r_q[WIDTH-1:1]};
            w_sout_nxt = r_q[0];
          end else begin
            w_q_nxt    = {r_q[WIDTH-2:0], sin};
            w_sout_nxt = r_q[WIDTH-1];
          end
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == CW'(1)) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign q    = r_q;
  assign sout = r_sout;
  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

`ifdef SHREG_PARITY_EN
  logic r_parity;
  // computed from the next q so it lands on the same edge as q
  always_ff @(posedge clk) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ^w_q_nxt;
  end
  assign parity = r_parity;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_uni_shift_reg.sv
// Bench for uni_shift_reg: directed plan steps then random traffic, against a behavioural model.
module tb_uni_shift_reg;
  localparam int W = 8, CW = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst, en, sin, start, bdir;
  logic [2:0] mode;
  logic [W-1:0] pdata;
  logic [CW-1:0] bcnt;
  logic [W-1:0] q;
  logic sout, busy, done, parity;

  int n_cmp = 0, n_bad = 0;
  int m_q, m_sout, m_busy, m_done, m_rem, m_dir;

  uni_shift_reg #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pdata(pdata),
    .start(start), .bdir(bdir), .bcnt(bcnt), .q(q), .sout(sout),
    .busy(busy), .done(done), .parity(parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int msb(input int v); return (v >> (W - 1)) & 1; endfunction

  // Model: q as an integer, a burst as "shifts remaining" plus a done flag.
  task automatic model_edge();
    int s = int'(sin);
    if (rst) begin
      m_q = 0; m_sout = 0; m_busy = 0; m_done = 0; m_rem = 0; m_dir = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_busy) begin
      if (en) begin
        if (m_dir) begin m_sout = m_q & 1; m_q = (m_q >> 1) + s * (1 << (W - 1)); end
        else begin m_sout = msb(m_q); m_q = ((m_q * 2) & MASK) + s; end
        m_rem--;
        if (m_rem == 0) m_done = 1;
      end
    end else if (start) begin
      m_busy = 1; m_rem = int'(bcnt); m_dir = int'(bdir);
      if (bcnt == 0) m_done = 1;
    end else if (en) begin
      case (mode)
        3'd1: m_q = int'(pdata);
        3'd2: begin m_sout = msb(m_q); m_q = ((m_q * 2) & MASK) + s; end
        3'd3: begin m_sout = m_q & 1; m_q = (m_q >> 1) + s * (1 << (W - 1)); end
        3'd4: begin m_sout = msb(m_q); m_q = ((m_q * 2) & MASK) + msb(m_q); end
        3'd5: begin m_sout = m_q & 1; m_q = (m_q >> 1) + (m_q & 1) * (1 << (W - 1)); end
        3'd6: begin m_sout = m_q & 1; m_q = (m_q >> 1) + msb(m_q) * (1 << (W - 1)); end
        3'd7: m_q = 0;
        default: ;
      endcase
    end
  endtask

  task automatic step();
    int exp_par;
    @(posedge clk);
    model_edge();
    #1;
`ifdef SHREG_PARITY_EN
    exp_par = $countones(m_q) % 2;
`else
    exp_par = 0;
`endif
    chk("q", 32'(q), 32'(m_q));
    chk("sout", 32'(sout), 32'(m_sout));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("parity", 32'(parity), 32'(exp_par));
  endtask

  task automatic load(input logic [W-1:0] v);
    mode = 3'd1; pdata = v; en = 1'b1; start = 1'b0; step();
  endtask

  initial begin
    logic [W-1:0] pat;
    rst = 1'b1; en = 1'b0; mode = 3'd0; sin = 1'b0; start = 1'b0;
    bdir = 1'b0; bcnt = '0; pdata = '0;
    m_q = 0; m_sout = 0; m_busy = 0; m_done = 0; m_rem = 0; m_dir = 0;
    step(); step();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    load(8'hA5);
    chk("load_A5", 32'(q), 32'hA5);
    load(8'h81);
    mode = 3'd2; sin = 1'b0; step();
    chk("shl_q", 32'(q), 32'h02); chk("shl_sout", 32'(sout), 32'h1);
    mode = 3'd5; step();
    chk("rotr_q", 32'(q), 32'h01); chk("rotr_sout", 32'(sout), 32'h0);
    load(8'h80);
    mode = 3'd6; step();
    chk("asr_q", 32'(q), 32'hC0);

    // serialise B4 MSB first
    load(8'hB4);
    pat = 8'hB4;
    mode = 3'd0; start = 1'b1; bcnt = 4'd8; bdir = 1'b0; sin = 1'b0; step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("ser_sout", 32'(sout), 32'(pat[7 - i]));
    end
    chk("ser_done", 32'(done), 32'h1);
    step();
    chk("ser_busy", 32'(busy), 32'h0);
    chk("ser_q", 32'(q), 32'h0);

    // stalled right burst with mode/start noise while busy
    load(8'h5A);
    mode = 3'd0; start = 1'b1; bcnt = 4'd3; bdir = 1'b1; sin = 1'b1; step();
    start = 1'b0; step();
    en = 1'b0; mode = 3'd7; start = 1'b1; step(); step();
    chk("stall_busy", 32'(busy), 32'h1);
    en = 1'b1; step(); step();
    chk("stall_done", 32'(done), 32'h1);
    chk("stall_q", 32'(q), 32'hEB);
    step();
    chk("stall_idle", 32'(busy), 32'h0);
    start = 1'b0; mode = 3'd0;

    // zero-length burst
    load(8'h3C);
    mode = 3'd0; start = 1'b1; bcnt = 4'd0; step();
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_q", 32'(q), 32'h3C);
    start = 1'b0; step();

    // reset mid-burst
    load(8'hFF);
    mode = 3'd0; start = 1'b1; bcnt = 4'd5; bdir = 1'b0; sin = 1'b0; step();
    start = 1'b0; step(); step();
    rst = 1'b1; step();
    chk("rstb_busy", 32'(busy), 32'h0);
    chk("rstb_q", 32'(q), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rstb_nodone", 32'(done), 32'h0);
    end

    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom % 60) == 0;
      en    = ($urandom % 4) != 0;
      mode  = 3'($urandom);
      sin   = 1'($urandom);
      start = ($urandom % 6) == 0;
      bdir  = 1'($urandom);
      bcnt  = CW'($urandom);
      pdata = W'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
